// File: rtl/not_unit_arbiter.sv
// Round-robin sequencer that shares one WIDTH-bit inverter among four requesters.
// Each operation walks IDLE -> LOAD -> EXEC -> RESP and returns ~operand with a one-cycle ack.
module not_unit_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    output logic [3:0]       ack,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [1:0]       gnt_id,
    output logic             busy,
    output logic [7:0]       op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [1:0]       ptr_r;
    logic [1:0]       winner_s;
    logic [WIDTH-1:0] op_reg_r;
    logic [WIDTH-1:0] din_sel_s;

    // First requester found when searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = p + k[1:0];
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Round-robin winner for the current request vector.
    always_comb begin
        winner_s = rr_pick(req, ptr_r);
    end

    // Operand mux selected by the registered grant.
    always_comb begin
        din_sel_s = din0;
        case (gnt_id)
            2'd0:    din_sel_s = din0;
            2'd1:    din_sel_s = din1;
            2'd2:    din_sel_s = din2;
            2'd3:    din_sel_s = din3;
            default: din_sel_s = din0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD:    state_s = EXEC;
            EXEC:    state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register; busy is registered from the next state so it tracks state != IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s != IDLE);
        end
    end

    // Grant capture and pointer update, only on IDLE -> LOAD; pointer resets to 3 so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_id <= 2'd0;
            ptr_r  <= 2'd3;
        end else if (state_r == IDLE && (|req)) begin
            gnt_id <= winner_s;
            ptr_r  <= winner_s;
        end
    end

    // Datapath: operand sampled only in LOAD, result and completion pulse produced in EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg_r   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ack        <= 4'b0000;
            op_count   <= 8'd0;
        end else begin
            case (state_r)
                LOAD: begin
                    op_reg_r <= din_sel_s;
                end
                EXEC: begin
                    dout       <= ~op_reg_r;
                    dout_valid <= 1'b1;
                    ack        <= 4'b0001 << gnt_id;
                    op_count   <= op_count + 8'd1;
                end
                RESP: begin
                    dout_valid <= 1'b0;
                    ack        <= 4'b0000;
                end
                default: begin
                    dout_valid <= 1'b0;
                    ack        <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_not_unit_arbiter.sv
// Self-checking bench for not_unit_arbiter: a timeline model of each operation
// checked every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_not_unit_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [7:0] din0 = 8'h00;
    logic [7:0] din1 = 8'h00;
    logic [7:0] din2 = 8'h00;
    logic [7:0] din3 = 8'h00;
    logic [3:0] ack;
    logic [7:0] dout;
    logic       dout_valid;
    logic [1:0] gnt_id;
    logic       busy;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    not_unit_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req(req),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .ack(ack), .dout(dout), .dout_valid(dout_valid),
        .gnt_id(gnt_id), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each operation is a timeline of cycles since the granting edge.
    int         m_phase = -1;
    int         m_ptr   = 3;
    logic [1:0] m_id    = 2'd0;
    logic [7:0] m_op    = 8'h00;
    logic [7:0] m_dout  = 8'h00;
    logic       m_valid = 1'b0;
    logic [3:0] m_ack   = 4'b0000;
    int         m_count = 0;

    function automatic logic [7:0] pick_din(input int id);
        case (id)
            0: return din0;
            1: return din1;
            2: return din2;
            default: return din3;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = -1; m_ptr = 3; m_id = 2'd0; m_op = 8'h00; m_dout = 8'h00;
            m_valid = 1'b0; m_ack = 4'b0000; m_count = 0;
        end else if (m_phase < 0) begin
            if (req != 4'b0000) begin
                for (int k = 1; k <= 4; k++) begin
                    if (req[(m_ptr + k) % 4]) begin
                        m_id = 2'((m_ptr + k) % 4);
                        break;
                    end
                end
                m_ptr   = int'(m_id);
                m_phase = 0;
            end
        end else begin
            m_phase++;
            if (m_phase == 1) m_op = pick_din(int'(m_id));
            if (m_phase == 2) begin
                m_dout  = ~m_op;
                m_valid = 1'b1;
                m_ack   = 4'b0001 << m_id;
                m_count = (m_count + 1) % 256;
            end
            if (m_phase == 3) begin
                m_valid = 1'b0;
                m_ack   = 4'b0000;
                m_phase = -1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en && !rst) begin
            chk("ack", 32'(ack), 32'(m_ack));
            chk("dout", 32'(dout), 32'(m_dout));
            chk("dout_valid", 32'(dout_valid), 32'(m_valid));
            chk("gnt_id", 32'(gnt_id), 32'(m_id));
            chk("busy", 32'(busy), 32'(m_phase >= 0));
            chk("op_count", 32'(op_count), 32'(m_count));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) for an ack pulse; n = negedges elapsed.
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 4'b0000 && n < 20);
        if (ack == 4'b0000) begin
            checks++;
            errors++;
            $display("FAIL wait_ack: no ack within %0d cycles at %0t", n, $time);
        end
    endtask

    logic [7:0] sim_din [4]  = '{8'h00, 8'hFF, 8'h0F, 8'h3C};
    logic [7:0] sim_exp [4]  = '{8'hFF, 8'h00, 8'hF0, 8'hC3};
    int         fair_id [6]  = '{0, 2, 0, 2, 0, 2};

    initial begin
        int n;
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_gnt", 32'(gnt_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_count", 32'(op_count), 32'h0);
        rst = 1'b0;
        check_en = 1'b1;

        // Single request
        @(negedge clk);
        din0 = 8'hA5;
        req  = 4'b0001;
        wait_ack(n);
        chk("single_lat", 32'(n), 32'd3);
        chk("single_ack", 32'(ack), 32'h1);
        chk("single_dout", 32'(dout), 32'h5A);
        chk("single_valid", 32'(dout_valid), 32'h1);
        chk("single_gnt", 32'(gnt_id), 32'h0);
        req = 4'b0000;
        @(negedge clk);
        chk("single_ack_off", 32'(ack), 32'h0);
        chk("single_valid_off", 32'(dout_valid), 32'h0);
        chk("single_dout_hold", 32'(dout), 32'h5A);
        chk("single_count", 32'(op_count), 32'h1);
        chk("single_busy_off", 32'(busy), 32'h0);

        // Simultaneous requests from a fresh pointer
        do_reset();
        din0 = sim_din[0]; din1 = sim_din[1]; din2 = sim_din[2]; din3 = sim_din[3];
        req  = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_ack(n);
            chk("sim_gnt", 32'(gnt_id), 32'(i));
            chk("sim_dout", 32'(dout), 32'(sim_exp[i]));
            if (i == 0) chk("sim_first_lat", 32'(n), 32'd3);
            else        chk("sim_spacing", 32'(n), 32'd4);
            req = req & ~ack;
        end
        chk("sim_count", 32'(op_count), 32'd4);
        repeat (2) @(negedge clk);

        // Reset mid-operation (in EXEC)
        req = 4'b0001;
        din0 = 8'h77;
        repeat (2) @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_ack", 32'(ack), 32'h0);
        chk("midrst_dout", 32'(dout), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_count", 32'(op_count), 32'h0);
        chk("midrst_valid", 32'(dout_valid), 32'h0);
        @(negedge clk);
        req = 4'b0000;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_ack", 32'(ack), 32'h0);
        end

        // Fairness between requesters 0 and 2 that never drop req
        din0 = 8'h01; din2 = 8'h02;
        req  = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            wait_ack(n);
            chk("fair_gnt", 32'(gnt_id), 32'(fair_id[i]));
            if (i > 0) chk("fair_spacing", 32'(n), 32'd4);
            if (i == 5) req = 4'b0000;
        end
        repeat (2) @(negedge clk);

        // Operand capture: din1 changes while EXEC
        din1 = 8'h11;
        req  = 4'b0010;
        repeat (2) @(negedge clk);
        din1 = 8'h22;
        wait_ack(n);
        chk("cap_dout", 32'(dout), 32'hEE);
        chk("cap_ack", 32'(ack), 32'h2);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // Counter wrap over 256 back-to-back operations
        do_reset();
        din0 = 8'h3C;
        req  = 4'b0001;
        for (int i = 1; i <= 256; i++) begin
            wait_ack(n);
            if (i == 1)   chk("wrap_dout", 32'(dout), 32'hC3);
            if (i == 255) chk("wrap_count_255", 32'(op_count), 32'd255);
            if (i == 256) begin
                chk("wrap_count_0", 32'(op_count), 32'd0);
                req = 4'b0000;
            end
        end
        repeat (3) @(negedge clk);
        chk("end_busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/not_unit_arbiter.md
# not_unit_arbiter

Round-robin arbiter and sequencer that shares a single WIDTH-bit bitwise inverter (NOT unit) among four requesters. Each requester presents an operand and holds a request. The block grants one requester at a time, captures its operand, drives it through the shared inverter and returns the registered result with a one-cycle acknowledge. It sits between the requesting datapath blocks and the one physical NOT bank, so the bank never sees two operands in the same operation.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-requester request; bit i belongs to requester i; level, held until ack.
- din0  input  WIDTH  operand of requester 0.
- din1  input  WIDTH  operand of requester 1.
- din2  input  WIDTH  operand of requester 2.
- din3  input  WIDTH  operand of requester 3.
- ack  output  4  one-hot, one-cycle completion pulse to the granted requester.
- dout  output  WIDTH  registered result, equal to ~operand; shared by all requesters.
- dout_valid  output  1  high for exactly the ack cycle.
- gnt_id  output  2  index of the current or most recent grant.
- busy  output  1  high while an operation is in flight.
- op_count  output  8  count of completed operations; wraps 255→0.

## Operation
State machine states: IDLE, LOAD, EXEC, RESP.

- **IDLE**
  - If req != 0, select the winner by round robin, register it into gnt_id and go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD**
  - op_reg <= din[gnt_id], then go to EXEC.
  - This is the only cycle in which the operand is sampled.
- **EXEC**
  - dout <= ~op_reg (the shared inverter output).
  - dout_valid <= 1, ack[gnt_id] <= 1, op_count <= op_count + 1 (mod 256).
  - Go to RESP.
- **RESP**
  - ack <= 0, dout_valid <= 0, then go to IDLE.

Round-robin rule:
- The pointer holds the last granted index. Search order after granting i is i+1, i+2, i+3, i (mod 4).
- The pointer updates only on the IDLE→LOAD transition.
- Reset value of the pointer is 3, so requester 0 has first priority.

busy is decoded from the state register: 1 in LOAD, EXEC and RESP; 0 in IDLE.

dout keeps the last result after dout_valid falls and changes only in EXEC.

Boundary conditions:
- **req dropped after grant:** ignored. The operation completes and ack is still issued.
- **din changes after LOAD:** no effect on the result.
- **req still high in IDLE after its ack:** treated as a new request, arbitrated normally. The requester sits behind the other active requesters.
- **Simultaneous requests:** exactly one grant per operation, chosen by round robin.
- **Reset at any time, including mid-operation:**
  - All outputs return to their reset values immediately; state goes to IDLE and the pointer to 3.
  - The interrupted requester receives no ack.
- **Reset values:** ack 0, dout 0, dout_valid 0, gnt_id 0, busy 0, op_count 0, op_reg 0.

## Timing
- Let E0 be the rising edge at which IDLE samples req != 0.
  - E0: gnt_id registered; busy rises.
  - E1: operand captured.
  - E2: dout, dout_valid and ack[gnt_id] asserted.
  - E3: ack and dout_valid cleared; busy falls.
  - E4: earliest next arbitration.
- Latency from the sampling edge to the result: 2 edges (result visible after E2).
- Throughput: one operation per 4 cycles.
- Requester obligation: deassert req in the cycle after ack is seen, so the request is low at the next IDLE sample (E4).
- All outputs are registered. No combinational path exists from req or din to any output.

## Test plan
- **Reset mid-operation:** req=4'b0001, assert rst in EXEC → ack=0, dout=0, busy=0, op_count=0 immediately; no ack afterwards.
- **Single request:** req=4'b0001, din0=8'hA5 → gnt_id=0 at E0, then ack=4'b0001, dout=8'h5A and dout_valid=1 for exactly one cycle after E2, then op_count=1.
- **Simultaneous requests:** req=4'b1111 with din0..din3=8'h00/8'hFF/8'h0F/8'h3C, each requester dropping req after its ack → grants 0,1,2,3 in order, dout=8'hFF/8'h00/8'hF0/8'hC3, acks 4 cycles apart.
- **Fairness:** requesters 0 and 2 re-request immediately after every ack → grant sequence 0,2,0,2,…; requester 2 is never skipped.
- **Operand capture:** req=4'b0010, din1=8'h11, din1 changed to 8'h22 in EXEC → dout=8'hEE.
- **Counter wrap:** 256 back-to-back single-requester operations → op_count reaches 255, then reads 0 after the 256th ack.
